i2d_if_pf: RTL and testbench



---
 rtl/i2d_defines.sv | 21 ++
 rtl/i2d_fifo.sv | 59 +++++
 rtl/i2d_if_pf.sv | 150 +++++++++++++++
 tb/tb_i2d_if_pf.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2d_defines.sv
// i2d_defines: definitions shared by the i2d instruction fetch path.
//   `I2D_INS_NOP : 6-bit opcode of the NOP instruction (overridable)
//   INS_NOP_OP   : the same opcode as a typed constant
//   NOP_WORD     : 32-bit NOP instruction word
//   if_state_e   : fetch bus master states
`ifndef I2D_INS_NOP
`define I2D_INS_NOP 6'b010101
`endif

package i2d_defines;

    localparam logic [5:0]  INS_NOP_OP = `I2D_INS_NOP;
    localparam logic [31:0] NOP_WORD   = {INS_NOP_OP, 26'b0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no request on the bus
        ST_REQ  = 2'd1,  // cyc/stb asserted at the fetch PC
        ST_ERR  = 2'd2   // bus halted after err_i, waits for a redirect
    } if_state_e;

endpackage

// File: rtl/i2d_fifo.sv
// i2d_fifo: DEPTH-entry synchronous FIFO with flush.
//   clk, rst         : clock, asynchronous active-high reset
//   flush_i          : synchronous flush (wins over push/pop)
//   push_i, wdata_i  : write port, ignored when full
//   pop_i, rdata_o   : read port, rdata_o shows the head entry; pop ignored when empty
//   full_o, empty_o  : occupancy flags
//   count_o          : number of stored entries (0..DEPTH)
module i2d_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/i2d_if_pf.sv
// i2d_if_pf: prefetching instruction fetch unit (Wishbone master + FIFO).
//   clk, rst                : clock, asynchronous active-high reset
//   adr_o, cyc_o, stb_o     : registered Wishbone request, one outstanding transfer
//   dat_i, ack_i, rty_i, err_i : Wishbone response (priority err > rty > ack)
//   set_pc, new_pc          : redirect; flushes FIFO, clears error, refetches
//   if_rd                   : decode pops the head entry
//   if_valid, if_ins, if_pc : head entry (NOP / 0 when empty)
//   if_busy                 : FIFO empty while a request is outstanding
//   if_err                  : sticky fetch error, cleared by set_pc
// Build option: define I2D_IF_BYPASS_EN to forward an ack straight to the
// decode outputs when the FIFO is empty.
module i2d_if_pf
    import i2d_defines::*;
#(
    parameter int unsigned    AW     = 32,
    parameter int unsigned    DW     = 32,
    parameter int unsigned    DEPTH  = 4,
    parameter logic [AW-1:0]  RST_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] adr_o,
    output logic          cyc_o,
    output logic          stb_o,
    input  logic [DW-1:0] dat_i,
    input  logic          ack_i,
    input  logic          rty_i,
    input  logic          err_i,
    input  logic          set_pc,
    input  logic [AW-1:0] new_pc,
    input  logic          if_rd,
    output logic          if_valid,
    output logic [DW-1:0] if_ins,
    output logic [AW-1:0] if_pc,
    output logic          if_busy,
    output logic          if_err
);

    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] NOP_INS = {INS_NOP_OP, {(DW-6){1'b0}}};

    if_state_e        state_q;
    logic [AW-1:0]    pc_q;
    logic             stb_q;

    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_cnt;
    logic [AW+DW-1:0] head;
    logic             acc, push, pop, room;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^new_pc[1:0];

    // A word is accepted only on a clean ack that is not overridden by
    // err/rty or discarded by a concurrent redirect.
    assign acc = (state_q == ST_REQ) && ack_i && !rty_i && !err_i && !set_pc;
    assign pop = if_rd && !fifo_empty && !set_pc;

`ifdef I2D_IF_BYPASS_EN
    logic byp;
    assign byp  = acc && fifo_empty;
    assign push = acc && !(byp && if_rd);

    always_comb begin
        if_valid = !fifo_empty || byp;
        if_ins   = NOP_INS;
        if_pc    = '0;
        if (!fifo_empty) begin
            if_ins = head[DW-1:0];
            if_pc  = head[AW+DW-1:DW];
        end else if (byp) begin
            if_ins = dat_i;
            if_pc  = pc_q;
        end
    end
`else
    assign push = acc;

    always_comb begin
        if_valid = !fifo_empty;
        if_ins   = NOP_INS;
        if_pc    = '0;
        if (!fifo_empty) begin
            if_ins = head[DW-1:0];
            if_pc  = head[AW+DW-1:DW];
        end
    end
`endif

    // Keep requesting while the FIFO will not be full after this cycle's
    // push/pop; with no push that reduces to "not full, or popping now".
    assign room = push ? ((fifo_cnt + CW'(1) - CW'(pop)) < CW'(DEPTH))
                       : (!fifo_full || pop);

    assign adr_o   = pc_q;
    assign cyc_o   = stb_q;
    assign stb_o   = stb_q;
    assign if_busy = fifo_empty && stb_q;
    assign if_err  = (state_q == ST_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stb_q   <= 1'b0;
            pc_q    <= RST_PC;
        end else if (set_pc) begin
            state_q <= ST_REQ;
            stb_q   <= 1'b1;
            pc_q    <= {new_pc[AW-1:2], 2'b00};
        end else begin
            case (state_q)
                ST_IDLE, ST_REQ: begin
                    if (state_q == ST_REQ && err_i) begin
                        state_q <= ST_ERR;
                        stb_q   <= 1'b0;
                    end else begin
                        if (acc) pc_q <= pc_q + AW'(4);
                        state_q <= room ? ST_REQ : ST_IDLE;
                        stb_q   <= room;
                    end
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                    stb_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    stb_q   <= 1'b0;
                end
            endcase
        end
    end

    i2d_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (set_pc),
        .push_i  (push),
        .wdata_i ({pc_q, dat_i}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_i2d_if_pf.sv
// tb_i2d_if_pf: scoreboard bench for i2d_if_pf. The driver acts as a Wishbone
// slave and as decode; the model is a queue of expected {pc, ins} words plus
// the expected fetch PC and error flag. A negedge monitor compares the DUT's
// visible state with the model and pops on every consumed word.
module tb_i2d_if_pf;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RSTPC = 32'h0;
    localparam logic [31:0] NOPW  = 32'h5400_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] adr_o;
    logic          cyc_o, stb_o;
    logic [DW-1:0] dat_i = '0;
    logic          ack_i = 1'b0, rty_i = 1'b0, err_i = 1'b0;
    logic          set_pc = 1'b0;
    logic [AW-1:0] new_pc = '0;
    logic          if_rd = 1'b0;
    logic          if_valid;
    logic [DW-1:0] if_ins;
    logic [AW-1:0] if_pc;
    logic          if_busy, if_err;

    i2d_if_pf #(
        .AW     (AW),
        .DW     (DW),
        .DEPTH  (DEPTH),
        .RST_PC (RSTPC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .adr_o    (adr_o),
        .cyc_o    (cyc_o),
        .stb_o    (stb_o),
        .dat_i    (dat_i),
        .ack_i    (ack_i),
        .rty_i    (rty_i),
        .err_i    (err_i),
        .set_pc   (set_pc),
        .new_pc   (new_pc),
        .if_rd    (if_rd),
        .if_valid (if_valid),
        .if_ins   (if_ins),
        .if_pc    (if_pc),
        .if_busy  (if_busy),
        .if_err   (if_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        q[$];
    logic [31:0] pc_m  = RSTPC;
    bit          err_m = 1'b0;
    bit          run   = 1'b0;
    bit          scr   = 1'b0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] wdata(input logic [31:0] a);
        return scr ? (a ^ 32'h5A5A_0F0F) : a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        q.delete();
        pc_m  = RSTPC;
        err_m = 1'b0;
        run   = 1'b0;
    endtask

    // Apply what the DUT saw at this edge to the model.
    task automatic commit();
        if (rst) begin
            reset_model();
        end else begin
            run = 1'b1;
            if (set_pc) begin
                q.delete();
                pc_m  = new_pc & 32'hFFFF_FFFC;
                err_m = 1'b0;
            end else if (err_i) begin
                err_m = 1'b1;
            end else if (rty_i) begin
                // retried next cycle at the same address
            end else if (ack_i) begin
                q.push_back('{pc: pc_m, ins: wdata(pc_m)});
                pc_m = pc_m + 32'd4;
            end
        end
    endtask

    // One clock: commit the previous cycle, then drive new inputs. The
    // slave only responds while a strobe is presented.
    task automatic cycle(input bit a, input bit r, input bit e, input bit rd,
                         input bit sp, input logic [31:0] np);
        @(posedge clk);
        commit();
        #1;
        ack_i  = a && stb_o;
        rty_i  = r && stb_o;
        err_i  = e && stb_o;
        dat_i  = wdata(adr_o);
        if_rd  = rd;
        set_pc = sp;
        new_pc = np;
    endtask

    task automatic do_reset();
        #1;
        rst    = 1'b1;
        ack_i  = 1'b0;
        rty_i  = 1'b0;
        err_i  = 1'b0;
        set_pc = 1'b0;
        if_rd  = 1'b0;
        reset_model();
        #1;
        chk("rst_cyc", cyc_o, 1'b0);
        chk("rst_stb", stb_o, 1'b0);
        chk("rst_adr", adr_o, RSTPC);
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_ins", if_ins, NOPW);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_busy", if_busy, 1'b0);
        chk("rst_err", if_err, 1'b0);
        repeat (2) cycle(0, 0, 0, 0, 0, '0);
        rst = 1'b0;
    endtask

    // Monitor: compare visible state with the model, pop consumed words.
    initial begin
        bit exp_stb;
        forever begin
            @(negedge clk);
            exp_stb = run && !err_m && (q.size() < DEPTH);
            chk("stb_o", stb_o, exp_stb);
            chk("cyc_o", cyc_o, exp_stb);
            if (exp_stb) chk("adr_o", adr_o, pc_m);
            chk("if_valid", if_valid, q.size() != 0);
            chk("if_busy", if_busy, exp_stb && (q.size() == 0));
            chk("if_err", if_err, err_m);
            if (q.size() != 0) begin
                chk("if_pc", if_pc, q[0].pc);
                chk("if_ins", if_ins, q[0].ins);
                if (if_rd && !set_pc && !rst) void'(q.pop_front());
            end else begin
                chk("idle_ins", if_ins, NOPW);
                chk("idle_pc", if_pc, 32'h0);
            end
        end
    end

    initial begin
        // Zero-wait slave returning the address, decode always reading.
        do_reset();
        repeat (16) cycle(1, 0, 0, 1, 0, '0);

        // Decode stalled: FIFO fills to DEPTH and fetch stops, then resumes.
        scr = 1'b1;
        do_reset();
        repeat (10) cycle(1, 0, 0, 0, 0, '0);
        repeat (10) cycle(1, 0, 0, 1, 0, '0);

        // Retry held for three cycles at address 8.
        do_reset();
        repeat (2) cycle(1, 0, 0, 0, 0, '0);
        repeat (3) cycle(0, 1, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, 0, '0);
        repeat (6) cycle(0, 0, 0, 1, 0, '0);

        // Bus error at 12: earlier words still drain, redirect recovers.
        do_reset();
        repeat (3) cycle(1, 0, 0, 0, 0, '0);
        cycle(0, 0, 1, 0, 0, '0);
        repeat (5) cycle(0, 0, 0, 1, 0, '0);
        cycle(0, 0, 0, 0, 1, 32'h100);
        repeat (6) cycle(1, 0, 0, 1, 0, '0);

        // Redirect coincident with an ack: word discarded, misaligned target.
        do_reset();
        cycle(1, 0, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, 1, 32'h203);
        repeat (6) cycle(1, 0, 0, 1, 0, '0);

        // Randomized traffic including combined ack/rty/err and redirects.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit a, r, e, rd, sp;
            a  = ($urandom_range(0, 99) < 65);
            r  = ($urandom_range(0, 99) < 20);
            e  = ($urandom_range(0, 99) < 2);
            rd = ($urandom_range(0, 3) != 0);
            sp = err_m ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 3);
            cycle(a, r, e, rd, sp, $urandom);
        end

        // Reset asserted during a strobed, acked cycle.
        do_reset();
        repeat (3) cycle(1, 0, 0, 1, 0, '0);
        do_reset();
        repeat (6) cycle(1, 0, 0, 1, 0, '0);
        repeat (8) cycle(0, 0, 0, 1, 0, '0);

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
